// File: rtl/huff_freq_count_pkg.sv
// Shared types and constants for the huffman symbol-frequency counter.
// Word layout is {valid, freq, char}, matching the encoder input.
package huff_pkg;

  localparam int CHAR_W   = 8;
  localparam int FREQ_W   = 3;
  localparam int NUM_SYMS = 3;
  localparam int IDX_W    = 2;
  localparam int WORD_W   = 1 + FREQ_W + CHAR_W;

  localparam int VALID_BIT = 11;
  localparam int FREQ_LSB  = 8;
  localparam int CHAR_LSB  = 0;

  localparam logic [FREQ_W-1:0] FREQ_MAX = '1;

  typedef enum logic [1:0] {
    COLLECT   = 2'd0,
    EMIT      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] mk_word(
    input logic [FREQ_W-1:0] f,
    input logic [CHAR_W-1:0] c
  );
    logic [WORD_W-1:0] w;
    w = '0;
    w[VALID_BIT] = 1'b1;
    w[FREQ_LSB +: FREQ_W] = f;
    w[CHAR_LSB +: CHAR_W] = c;
    return w;
  endfunction

endpackage

// File: rtl/huff_freq_count_if.sv
// Byte-stream input, encoder word output and status flags.
// master: upstream/encoder side; slave: the counter.
interface huff_freq_count_if;
  import huff_pkg::*;

  logic              in_valid;
  logic [CHAR_W-1:0] in_char;
  logic              in_last;
  logic              in_ready;
  logic [WORD_W-1:0] enc_word;
  logic              enc_done;
  logic              sat_err;
  logic              sym_err;

  modport master (
    output in_valid, in_char, in_last, enc_done,
    input  in_ready, enc_word, sat_err, sym_err
  );

  modport slave (
    input  in_valid, in_char, in_last, enc_done,
    output in_ready, enc_word, sat_err, sym_err
  );

endinterface

// File: rtl/huff_sym_table.sv
// Symbol table: parallel match, lowest-free allocate, saturating count.
// Ports: clear/upd/sym update, sat/drop status, rd_idx read port.
module huff_sym_table
  import huff_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              upd,
  input  logic [CHAR_W-1:0] sym,
  output logic              sat,
  output logic              drop,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [FREQ_W-1:0] rd_freq,
  output logic [CHAR_W-1:0] rd_char
);

  logic [NUM_SYMS-1:0] used_q, used_d;
  logic [FREQ_W-1:0]   freq_q [NUM_SYMS];
  logic [FREQ_W-1:0]   freq_d [NUM_SYMS];
  logic [CHAR_W-1:0]   char_q [NUM_SYMS];
  logic [CHAR_W-1:0]   char_d [NUM_SYMS];

  logic [NUM_SYMS-1:0] hit;
  logic                any_hit;
  logic                hit_max;
  logic [IDX_W-1:0]    free_idx;
  logic                any_free;

  always_comb begin
    used_d   = used_q;
    freq_d   = freq_q;
    char_d   = char_q;
    hit      = '0;
    any_hit  = 1'b0;
    hit_max  = 1'b0;
    free_idx = '0;
    any_free = 1'b0;
    sat      = 1'b0;
    drop     = 1'b0;

    for (int i = 0; i < NUM_SYMS; i++) begin
      if (used_q[i] && char_q[i] == sym) begin
        hit[i]  = 1'b1;
        any_hit = 1'b1;
        if (freq_q[i] == FREQ_MAX) hit_max = 1'b1;
      end
    end

    // Descending scan leaves the lowest free index.
    for (int i = NUM_SYMS - 1; i >= 0; i--) begin
      if (!used_q[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
    end

    if (clear) begin
      for (int i = 0; i < NUM_SYMS; i++) begin
        used_d[i] = 1'b0;
        freq_d[i] = '0;
        char_d[i] = '0;
      end
    end else if (upd) begin
      if (any_hit) begin
        sat = hit_max;
        for (int i = 0; i < NUM_SYMS; i++) begin
          if (hit[i] && !hit_max) freq_d[i] = freq_q[i] + 1'b1;
        end
      end else if (any_free) begin
        for (int i = 0; i < NUM_SYMS; i++) begin
          if (IDX_W'(i) == free_idx) begin
            used_d[i] = 1'b1;
            freq_d[i] = FREQ_W'(1);
            char_d[i] = sym;
          end
        end
      end else begin
        drop = 1'b1;
      end
    end
  end

  // Read the post-update view so word 0 already counts the final byte.
  always_comb begin
    rd_freq = '0;
    rd_char = '0;
    for (int i = 0; i < NUM_SYMS; i++) begin
      if (IDX_W'(i) == rd_idx) begin
        rd_freq = freq_d[i];
        rd_char = char_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      used_q <= '0;
      for (int i = 0; i < NUM_SYMS; i++) begin
        freq_q[i] <= '0;
        char_q[i] <= '0;
      end
    end else begin
      used_q <= used_d;
      for (int i = 0; i < NUM_SYMS; i++) begin
        freq_q[i] <= freq_d[i];
        char_q[i] <= char_d[i];
      end
    end
  end

endmodule

// File: rtl/huff_freq_count.sv
// Counts symbol frequencies of one message and emits the table.
// Ports: clk, reset, bus (slave: byte in, enc word out, flags).
module huff_freq_count
  import huff_pkg::*;
(
  input logic               clk,
  input logic               reset,
  huff_freq_count_if.slave  bus
);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              sat_q, sym_q;

  logic              accept;
  logic              done;
  logic              t_sat, t_drop;
  logic [IDX_W-1:0]  rd_idx;
  logic [FREQ_W-1:0] rd_freq;
  logic [CHAR_W-1:0] rd_char;

  assign accept = bus.in_valid && state_q == COLLECT;
  assign done   = bus.enc_done && state_q == WAIT_DONE;

  // Word register loads one entry ahead of the emit index.
  assign rd_idx = (state_q == EMIT) ? idx_q + 1'b1 : '0;

  huff_sym_table u_table (
    .clk     (clk),
    .reset   (reset),
    .clear   (done),
    .upd     (accept),
    .sym     (bus.in_char),
    .sat     (t_sat),
    .drop    (t_drop),
    .rd_idx  (rd_idx),
    .rd_freq (rd_freq),
    .rd_char (rd_char)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = '0;
    case (state_q)
      COLLECT: begin
        if (accept && bus.in_last) begin
          state_d = EMIT;
          idx_d   = '0;
          word_d  = mk_word(rd_freq, rd_char);
        end
      end
      EMIT: begin
        if (idx_q == IDX_W'(NUM_SYMS - 1)) begin
          state_d = WAIT_DONE;
        end else begin
          idx_d  = idx_q + 1'b1;
          word_d = mk_word(rd_freq, rd_char);
        end
      end
      WAIT_DONE: begin
        if (done) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      word_q  <= '0;
      sat_q   <= 1'b0;
      sym_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      if (done) begin
        sat_q <= 1'b0;
        sym_q <= 1'b0;
      end else begin
        if (accept && t_sat)  sat_q <= 1'b1;
        if (accept && t_drop) sym_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready = (state_q == COLLECT);
  assign bus.enc_word = word_q;
  assign bus.sat_err  = sat_q;
  assign bus.sym_err  = sym_q;

endmodule

// File: tb/tb_huff_freq_count.sv
// Scoreboard bench for huff_freq_count with a message-level model.
// Directed cases plus randomized messages.
module tb_huff_freq_count;
  import huff_pkg::*;

  logic clk = 1'b0;
  logic reset;

  huff_freq_count_if bus();

  huff_freq_count dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  msg[$];
  logic [11:0] exp_q[$];
  bit          exp_sat;
  bit          exp_sym;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Model: distinct symbols in first-seen order, counts capped at 7.
  function automatic void model();
    logic [7:0] ch[$];
    int         cnt[$];
    bit         found;
    exp_sat = 0;
    exp_sym = 0;
    foreach (msg[i]) begin
      found = 0;
      foreach (ch[j]) begin
        if (ch[j] == msg[i]) begin
          found = 1;
          if (cnt[j] == 7) exp_sat = 1;
          else cnt[j] = cnt[j] + 1;
        end
      end
      if (!found) begin
        if (ch.size() < 3) begin
          ch.push_back(msg[i]);
          cnt.push_back(1);
        end else begin
          exp_sym = 1;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (k < ch.size()) exp_q.push_back({1'b1, 3'(cnt[k]), ch[k]});
      else exp_q.push_back(12'h800);
    end
  endfunction

  // Monitor: every valid word must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    logic [11:0] e;
    if (!reset && bus.enc_word[VALID_BIT] === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%0h expected=none",
                 bus.enc_word);
      end else begin
        e = exp_q.pop_front();
        chk("enc_word", 32'(bus.enc_word), 32'(e));
      end
    end
  end

  task automatic send_msg(input bit gaps);
    for (int i = 0; i < msg.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b1;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_char  = msg[i];
      bus.in_last  = (i == msg.size() - 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Entered one step after the final byte is accepted.
  task automatic finish_msg(input bit poke, input bit hold);
    if (poke) bus.enc_done = 1'b1;
    @(posedge clk); #1;
    bus.enc_done = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wait_word", 32'(bus.enc_word), 0);
    chk("wait_ready", 32'(bus.in_ready), 0);
    chk("wait_sat", 32'(bus.sat_err), 32'(exp_sat));
    chk("wait_sym", 32'(bus.sym_err), 32'(exp_sym));
    chk("emit_count", exp_q.size(), 0);
    if (hold) begin
      bus.in_valid = 1'b1;
      bus.in_char  = 8'h41;
      bus.in_last  = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        chk("hold_ready", 32'(bus.in_ready), 0);
        chk("hold_word", 32'(bus.enc_word), 0);
      end
    end
    bus.enc_done = 1'b1;
    @(posedge clk); #1;
    bus.enc_done = 1'b0;
    chk("done_ready", 32'(bus.in_ready), 1);
    chk("done_sat", 32'(bus.sat_err), 0);
    chk("done_sym", 32'(bus.sym_err), 0);
  endtask

  task automatic run(input bit gaps, input bit poke);
    model();
    send_msg(gaps);
    finish_msg(poke, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, alpha;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_char  = '0;
    bus.in_last  = 1'b0;
    bus.enc_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_word", 32'(bus.enc_word), 0);
    chk("rst_ready", 32'(bus.in_ready), 1);
    chk("rst_sat", 32'(bus.sat_err), 0);
    chk("rst_sym", 32'(bus.sym_err), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    msg = '{8'h41, 8'h42, 8'h41};
    run(1'b0, 1'b1);

    msg = {};
    repeat (9) msg.push_back(8'h43);
    run(1'b0, 1'b0);

    msg = '{8'h41, 8'h42, 8'h43, 8'h44};
    run(1'b0, 1'b0);

    msg = '{8'h41, 8'h42};
    model();
    send_msg(1'b0);
    finish_msg(1'b0, 1'b1);
    msg = '{8'h41};
    model();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    finish_msg(1'b0, 1'b0);

    msg = '{8'h41, 8'h42, 8'h41};
    model();
    send_msg(1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_emit_word", 32'(bus.enc_word), 0);
    chk("rst_emit_ready", 32'(bus.in_ready), 1);
    chk("rst_emit_left", exp_q.size(), 2);
    exp_q.delete();
    reset = 1'b0;
    msg = '{8'h42};
    run(1'b0, 1'b0);

    msg = '{8'h41, 8'h42};
    run(1'b0, 1'b0);
    msg = '{8'h43, 8'h43};
    run(1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      len   = $urandom_range(1, 10);
      alpha = $urandom_range(1, 5);
      msg = {};
      for (int i = 0; i < len; i++)
        msg.push_back(8'h41 + 8'($urandom_range(0, alpha - 1)));
      run(1'b1, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
